// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, 33-cycle latency).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 product.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [1:0]      op_reg;
  logic            neg_reg, rneg_reg;
  logic [XLEN-1:0] hi_reg, lo_reg, opnd_reg;
  logic [4:0]      cnt_reg;
  logic [XLEN-1:0] pend_res_reg, result_reg;
  logic [4:0]      pend_rd_reg, rd_reg;

  // Operand decode; only meaningful while IDLE and accepting.
  logic            a_signed, b_signed, sa, sb, div_zero, div_ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    a_mag    = sa ? -op_a : op_a;
    b_mag    = sb ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    accept   = (state_reg == S_IDLE) && start && !flush;
  end

  // One iteration step; hi/lo/opnd hold {acc, multiplier, multiplicand} or {rem, quo, divisor}.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_rem, div_quo;
  logic [2*XLEN-1:0] prod_abs, prod_signed;
  logic [XLEN-1:0]   quo_signed, rem_signed, iter_res;
  always_comb begin
    mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_hi      = mul_sum[XLEN:1];
    mul_lo      = {mul_sum[0], lo_reg[XLEN-1:1]};
    div_sh      = {hi_reg, lo_reg[XLEN-1]};
    div_diff    = div_sh - {1'b0, opnd_reg};
    div_rem     = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
    div_quo     = {lo_reg[XLEN-2:0], ~div_diff[XLEN]};
    prod_abs    = {mul_hi, mul_lo};
    prod_signed = neg_reg ? -prod_abs : prod_abs;
    quo_signed  = neg_reg ? -div_quo : div_quo;
    rem_signed  = rneg_reg ? -div_rem : div_rem;
    iter_res    = '0;
    if (state_reg == S_MUL)
      iter_res = (op_reg == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    else
      iter_res = op_reg[1] ? rem_signed : quo_signed;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;
  logic [XLEN-1:0]          fast_res;
  always_comb begin
    fast_a    = {a_signed & op_a[XLEN-1], op_a};
    fast_b    = {b_signed & op_b[XLEN-1], op_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (!funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            state_next = S_DONE;
`else
            state_next = S_MUL;
`endif
          end else if (div_zero || div_ovf) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush)               state_next = S_IDLE;
        else if (cnt_reg == '0)  state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The pending result is shown only during the done pulse and committed when it is not flushed.
  always_comb begin
    busy   = (state_reg != S_IDLE);
    done   = (state_reg == S_DONE) && !flush;
    wb_we  = done && (pend_rd_reg != 5'd0);
    rd_out = done ? pend_rd_reg : rd_reg;
    result = done ? pend_res_reg : result_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg       <= '0;
      neg_reg      <= 1'b0;
      rneg_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      opnd_reg     <= '0;
      cnt_reg      <= '0;
      pend_res_reg <= '0;
      pend_rd_reg  <= '0;
      result_reg   <= '0;
      rd_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg      <= funct3[1:0];
            neg_reg     <= sa ^ sb;
            rneg_reg    <= sa;
            cnt_reg     <= 5'd31;
            pend_rd_reg <= rd_in;
            if (!funct3[2]) begin
              hi_reg   <= '0;
              lo_reg   <= b_mag;
              opnd_reg <= a_mag;
`ifdef MULDIV_FAST_MUL_EN
              pend_res_reg <= fast_res;
`endif
            end else if (div_zero) begin
              pend_res_reg <= funct3[1] ? op_a : '1;
            end else if (div_ovf) begin
              // op_a is the most negative value here, which is also the DIV answer.
              pend_res_reg <= funct3[1] ? '0 : op_a;
            end else begin
              hi_reg   <= '0;
              lo_reg   <= a_mag;
              opnd_reg <= b_mag;
            end
          end
        end
        S_MUL, S_DIV: begin
          hi_reg  <= (state_reg == S_MUL) ? mul_hi : div_rem;
          lo_reg  <= (state_reg == S_MUL) ? mul_lo : div_quo;
          cnt_reg <= cnt_reg - 5'd1;
          if (cnt_reg == '0) pend_res_reg <= iter_res;
        end
        S_DONE: begin
          if (!flush) begin
            result_reg <= pend_res_reg;
            rd_reg     <= pend_rd_reg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are queued at issue and compared at done.
module tb_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_we;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] res; logic [4:0] rd; int lat; } exp_t;
  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [4:0] rd; } vec_t;
  exp_t        sb_q[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .wb_we(wb_we),
    .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000, 3'b011: p = {32'b0, a} * {32'b0, b};
      3'b001:         p = longint'(ia) * longint'(ib);
      3'b010:         p = longint'(ia) * longint'({32'b0, b});
      default:        p = 64'd0;
    endcase
    case (f3)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return ia / ib;
      3'b101: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'b110: if (b == 0) return a; else if (ovf) return 32'd0; else return ia % ib;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Called right after a falling edge; the next rising edge samples the request.
  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
  endtask

  // Waits (bounded) for done; lat = -1 on timeout. Operands are scrambled once accepted.
  task automatic wait_done(output logic [31:0] r, output logic [4:0] ro, output logic we,
                           output int lat, output logic done_after, output logic busy_after);
    lat = -1; r = '0; ro = '0; we = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      end
      if (done) begin
        lat = k; r = result; ro = rd_out; we = wb_we;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (wb_we !== 1'b0)  begin errors++; $display("FAIL reset_we: got %b expected 0", wb_we); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rd_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    $display("reset: outputs checked");
  endtask

  task automatic test_mul();
    vec_t v[$];
    exp_t e;
    logic [31:0] r; logic [4:0] ro; logic we, da, ba; int lat;
    v.push_back('{3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5});
    v.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd6});
    v.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd7});
    v.push_back('{3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 5'd8});
    v.push_back('{3'b000, 32'd6, 32'd7, 32'd42, 5'd9});
    v.push_back('{3'b000, 32'd3, 32'd4, 32'd12, 5'd0});
    foreach (v[i]) begin
      sb_q.push_back('{v[i].res, v[i].rd, exp_lat(v[i].f3, v[i].a, v[i].b)});
      drive_op(v[i].f3, v[i].a, v[i].b, v[i].rd);
      wait_done(r, ro, we, lat, da, ba);
      e = sb_q.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (r !== e.res)  begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, r, e.res); end
      checks++; if (ro !== e.rd)  begin errors++; $display("FAIL mul_rd[%0d]: got %0d expected %0d", i, ro, e.rd); end
      checks++; if (we !== (e.rd != 5'd0)) begin errors++; $display("FAIL mul_we[%0d]: got %b expected %b", i, we, e.rd != 5'd0); end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL mul_after[%0d]: done=%b busy=%b expected 0 0", i, da, ba); end
      last_res = e.res; last_rd = e.rd;
      $display("mul f3=%0d a=%h b=%h rd=%0d -> result=%h we=%b lat=%0d", v[i].f3, v[i].a, v[i].b, v[i].rd, r, we, lat);
    end
  endtask

  task automatic test_div();
    vec_t v[$];
    exp_t e;
    logic [31:0] r; logic [4:0] ro; logic we, da, ba; int lat;
    v.push_back('{3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 5'd10});
    v.push_back('{3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 5'd11});
    v.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 5'd12});
    v.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 5'd13});
    v.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd14});
    v.push_back('{3'b110, 32'd5, 32'd0, 32'd5, 5'd15});
    v.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd16});
    v.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd17});
    foreach (v[i]) begin
      sb_q.push_back('{v[i].res, v[i].rd, exp_lat(v[i].f3, v[i].a, v[i].b)});
      drive_op(v[i].f3, v[i].a, v[i].b, v[i].rd);
      wait_done(r, ro, we, lat, da, ba);
      e = sb_q.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (r !== e.res)  begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, e.res); end
      checks++; if (ro !== e.rd)  begin errors++; $display("FAIL div_rd[%0d]: got %0d expected %0d", i, ro, e.rd); end
      checks++; if (we !== 1'b1)  begin errors++; $display("FAIL div_we[%0d]: got %b expected 1", i, we); end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL div_after[%0d]: done=%b busy=%b expected 0 0", i, da, ba); end
      last_res = e.res; last_rd = e.rd;
      $display("div f3=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", v[i].f3, v[i].a, v[i].b, v[i].rd, r, lat);
    end
  endtask

  task automatic test_busy_flush();
    logic saw_done = 1'b0;
    drive_op(3'b100, 32'd1000, 32'd7, 5'd20);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd9; end
      if (k == 6) start = 1'b0;
      if (k == 10) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
        flush = 1'b1;
      end
      if (k == 11) begin
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
        checks++; if (result !== last_res) begin errors++; $display("FAIL flush_result: got %h expected %h", result, last_res); end
        checks++; if (rd_out !== last_rd) begin errors++; $display("FAIL flush_rd: got %0d expected %0d", rd_out, last_rd); end
      end
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
    $display("flush: DIV aborted at N+10, repeated start ignored");
  endtask

  task automatic test_reset_mid();
    drive_op(3'b101, 32'd12345, 32'd11, 5'd21);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) rst_n = 1'b0;
    end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (wb_we !== 1'b0)   begin errors++; $display("FAIL midrst_we: got %b expected 0", wb_we); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0)  begin errors++; $display("FAIL midrst_rd: got %0d expected 0", rd_out); end
    rst_n = 1'b1;
    last_res = '0; last_rd = '0;
    @(negedge clk);
    $display("reset mid-DIV: outputs cleared");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] r, a, b; logic [4:0] ro, rd; logic [2:0] f3; logic we, da, ba; int lat;
    for (int i = 0; i < 14; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      rd = (i == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      sb_q.push_back('{model(f3, a, b), rd, exp_lat(f3, a, b)});
      drive_op(f3, a, b, rd);
      wait_done(r, ro, we, lat, da, ba);
      e = sb_q.pop_front();
      checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
      checks++; if (r !== e.res)  begin errors++; $display("FAIL b2b_result[%0d]: f3=%0d a=%h b=%h got %h expected %h", i, f3, a, b, r, e.res); end
      checks++; if (ro !== e.rd)  begin errors++; $display("FAIL b2b_rd[%0d]: got %0d expected %0d", i, ro, e.rd); end
      checks++; if (we !== (e.rd != 5'd0)) begin errors++; $display("FAIL b2b_we[%0d]: got %b expected %b", i, we, e.rd != 5'd0); end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL b2b_after[%0d]: done=%b busy=%b expected 0 0", i, da, ba); end
      $display("b2b f3=%0d a=%h b=%h rd=%0d -> result=%h we=%b lat=%0d", f3, a, b, rd, r, we, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_busy_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
